// File: rtl/fme_pkg.sv
// Shared FME definitions: lane count, default sample width, SAD width and lane slicing helpers.
package fme_pkg;

    localparam int FME_LANES     = 8;
    localparam int FME_DATAWIDTH = 8;

    // Per-row tag that travels alongside the row sum through the row stage.
    typedef struct packed {
        logic first_row;   // row 0 of a block: accumulator loads instead of adding
        logic last_row;    // row ROWS-1: block completes
        logic last_cand;   // final row of the last candidate of the search
        logic srch;        // row 0 of candidate 0 of a new search
    } fme_row_tag_t;

    // Worst-case block SAD width: lane diff (dw) + 8 lanes (3) + row accumulation.
    function automatic int fme_sad_width(input int dw, input int rows);
        return dw + 3 + $clog2(rows);
    endfunction

    // LSB position of lane k in a packed lane vector.
    function automatic int fme_lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/fme_sad_row.sv
// Row SAD stage: 8-lane |orig - cand| followed by a 3-level adder tree.
// FME_SAD_PIPE_EN adds a register between the absolute-difference lanes and the tree.
module fme_sad_row
    import fme_pkg::*;
#(
    parameter int DATAWIDTH = FME_DATAWIDTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             valid_i,
    input  logic [FME_LANES*DATAWIDTH-1:0]   orig_i,
    input  logic [FME_LANES*DATAWIDTH-1:0]   cand_i,
    output logic                             valid_o,
    output logic [DATAWIDTH+2:0]             sum_o
);

    logic [FME_LANES-1:0][DATAWIDTH-1:0] ad;
    logic [FME_LANES-1:0][DATAWIDTH-1:0] tin;
    logic                                tin_vld;
    logic [3:0][DATAWIDTH:0]             l1;
    logic [1:0][DATAWIDTH+1:0]           l2;
    logic [DATAWIDTH+2:0]                tot;
    logic [DATAWIDTH+2:0]                sum_q;
    logic                                vld_q;

    // Unsigned absolute difference per lane via a (DATAWIDTH+1)-bit signed difference.
    for (genvar k = 0; k < FME_LANES; k++) begin : g_lane
        logic [DATAWIDTH-1:0] a, b;
        logic [DATAWIDTH:0]   diff, neg;
        assign a    = orig_i[fme_lane_lsb(k, DATAWIDTH) +: DATAWIDTH];
        assign b    = cand_i[fme_lane_lsb(k, DATAWIDTH) +: DATAWIDTH];
        assign diff = {1'b0, a} - {1'b0, b};
        assign neg  = -diff;
        assign ad[k] = diff[DATAWIDTH] ? neg[DATAWIDTH-1:0] : diff[DATAWIDTH-1:0];
    end

`ifdef FME_SAD_PIPE_EN
    logic [FME_LANES-1:0][DATAWIDTH-1:0] ad_q;
    logic                                ad_vld_q;

    // Retime the lane differences ahead of the tree.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ad_q     <= '0;
            ad_vld_q <= 1'b0;
        end else begin
            ad_q     <= ad;
            ad_vld_q <= valid_i;
        end
    end

    assign tin     = ad_q;
    assign tin_vld = ad_vld_q;
`else
    assign tin     = ad;
    assign tin_vld = valid_i;
`endif

    // Balanced tree, each level one bit wider than its inputs.
    always_comb begin
        l1  = '0;
        l2  = '0;
        for (int j = 0; j < 4; j++) l1[j] = {1'b0, tin[2*j]} + {1'b0, tin[2*j+1]};
        for (int j = 0; j < 2; j++) l2[j] = {1'b0, l1[2*j]} + {1'b0, l1[2*j+1]};
        tot = {1'b0, l2[0]} + {1'b0, l2[1]};
    end

    // Register the row sum and its qualifier.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sum_q <= tot;
            vld_q <= tin_vld;
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = vld_q;

endmodule

// File: rtl/fme_sad_accumulator.sv
// Block SAD accumulator with per-search minimum tracking.
// Row sums accumulate over ROWS beats; each completed block is compared against the best so far.
// Optional macro FME_SAD_PIPE_EN: extra register inside the row stage (all latencies +1).
module fme_sad_accumulator
    import fme_pkg::*;
#(
    parameter int DATAWIDTH = FME_DATAWIDTH,
    parameter int ROWS      = 8,
    parameter int CAND_W    = 4,
    localparam int SAD_W    = fme_sad_width(DATAWIDTH, ROWS)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic                             in_start,
    input  logic                             in_last_cand,
    input  logic [FME_LANES*DATAWIDTH-1:0]   orig,
    input  logic [FME_LANES*DATAWIDTH-1:0]   cand,
    output logic                             sad_valid,
    output logic [SAD_W-1:0]                 sad,
    output logic [CAND_W-1:0]                sad_index,
    output logic                             best_valid,
    output logic [SAD_W-1:0]                 best_sad,
    output logic [CAND_W-1:0]                best_index
);

    localparam int RW   = $clog2(ROWS);
    localparam int TW   = $bits(fme_row_tag_t);
    localparam int SB_W = TW + CAND_W;
`ifdef FME_SAD_PIPE_EN
    localparam int ROW_LAT = 2;
`else
    localparam int ROW_LAT = 1;
`endif

    // Beat-side counters
    logic [RW-1:0]     row_q, row_d, eff_row;
    logic [CAND_W-1:0] cand_q, cand_d, eff_cand;
    logic              start_v, row_last;
    fme_row_tag_t      tag_in;

    // Row stage outputs with matching tag
    logic [ROW_LAT-1:0][SB_W-1:0] sb_pipe;
    logic [SB_W-1:0]              sb_out;
    fme_row_tag_t                 rs_tag;
    logic [CAND_W-1:0]            rs_idx;
    logic                         rs_vld;
    logic [DATAWIDTH+2:0]         rs_sum;

    // Accumulate / output / tracker stages
    logic [SAD_W-1:0]  acc_q;
    logic              srch_q;
    logic              blk_done_q, blk_last_q, blk_first_q;
    logic [CAND_W-1:0] blk_idx_q;
    logic              sad_valid_q, sad_last_q, sad_first_q;
    logic [SAD_W-1:0]  sad_q;
    logic [CAND_W-1:0] sad_idx_q;
    logic [SAD_W-1:0]  trk_sad_q, base_sad, new_sad, best_sad_q;
    logic [CAND_W-1:0] trk_idx_q, base_idx, new_idx, best_idx_q;
    logic              best_valid_q;

    // Next row/candidate position; in_start forces the beat to row 0 of candidate 0.
    always_comb begin
        start_v  = in_valid & in_start;
        eff_row  = start_v ? '0 : row_q;
        eff_cand = start_v ? '0 : cand_q;
        row_last = (eff_row == RW'(ROWS - 1));
        row_d    = row_q;
        cand_d   = cand_q;
        if (in_valid) begin
            row_d  = eff_row + RW'(1);
            cand_d = eff_cand + CAND_W'(row_last);
        end
        tag_in.first_row = (eff_row == '0);
        tag_in.last_row  = row_last;
        tag_in.last_cand = in_last_cand & row_last;
        tag_in.srch      = start_v;
    end

    // Row and candidate counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q  <= '0;
            cand_q <= '0;
        end else begin
            row_q  <= row_d;
            cand_q <= cand_d;
        end
    end

    fme_sad_row #(.DATAWIDTH(DATAWIDTH)) u_row (
        .clock   (clock),
        .reset   (reset),
        .valid_i (in_valid),
        .orig_i  (orig),
        .cand_i  (cand),
        .valid_o (rs_vld),
        .sum_o   (rs_sum)
    );

    // Delay the row tag and candidate index to line up with the row sum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb_pipe <= '0;
        end else begin
            sb_pipe[0] <= {tag_in, eff_cand};
            for (int i = 1; i < ROW_LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
        end
    end

    assign sb_out = sb_pipe[ROW_LAT-1];
    assign rs_tag = fme_row_tag_t'(sb_out[SB_W-1:CAND_W]);
    assign rs_idx = sb_out[CAND_W-1:0];

    // Accumulate row sums; flag the block when its last row lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            srch_q      <= 1'b0;
            blk_done_q  <= 1'b0;
            blk_idx_q   <= '0;
            blk_last_q  <= 1'b0;
            blk_first_q <= 1'b0;
        end else begin
            blk_done_q <= rs_vld & rs_tag.last_row;
            if (rs_vld) begin
                acc_q <= rs_tag.first_row ? SAD_W'(rs_sum) : acc_q + SAD_W'(rs_sum);
                if (rs_tag.first_row) srch_q <= rs_tag.srch;
                if (rs_tag.last_row) begin
                    blk_idx_q   <= rs_idx;
                    blk_last_q  <= rs_tag.last_cand;
                    blk_first_q <= srch_q;
                end
            end
        end
    end

    // Present the completed block SAD; values hold between pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sad_valid_q <= 1'b0;
            sad_q       <= '0;
            sad_idx_q   <= '0;
            sad_last_q  <= 1'b0;
            sad_first_q <= 1'b0;
        end else begin
            sad_valid_q <= blk_done_q;
            if (blk_done_q) begin
                sad_q       <= acc_q;
                sad_idx_q   <= blk_idx_q;
                sad_last_q  <= blk_last_q;
                sad_first_q <= blk_first_q;
            end
        end
    end

    // Compare against the running best; the first block of a search sees a re-armed tracker,
    // so a start beat never disturbs the previous search still draining the pipeline.
    always_comb begin
        base_sad = sad_first_q ? '1 : trk_sad_q;
        base_idx = sad_first_q ? '0 : trk_idx_q;
        new_sad  = base_sad;
        new_idx  = base_idx;
        if (sad_q < base_sad) begin
            new_sad = sad_q;
            new_idx = sad_idx_q;
        end
    end

    // Best tracker update and search-end emission.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trk_sad_q    <= '1;
            trk_idx_q    <= '0;
            best_sad_q   <= '1;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
        end else begin
            best_valid_q <= sad_valid_q & sad_last_q;
            if (sad_valid_q) begin
                if (sad_last_q) begin
                    best_sad_q <= new_sad;
                    best_idx_q <= new_idx;
                    trk_sad_q  <= '1;
                    trk_idx_q  <= '0;
                end else begin
                    trk_sad_q  <= new_sad;
                    trk_idx_q  <= new_idx;
                end
            end
        end
    end

    assign sad_valid  = sad_valid_q;
    assign sad        = sad_q;
    assign sad_index  = sad_idx_q;
    assign best_valid = best_valid_q;
    assign best_sad   = best_sad_q;
    assign best_index = best_idx_q;

endmodule

// File: tb/tb_fme_sad_accumulator.sv
// Directed bench for fme_sad_accumulator (default parameters).
module tb_fme_sad_accumulator;

`ifdef FME_SAD_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_start = 1'b0;
    logic        in_last_cand = 1'b0;
    logic [63:0] orig = '0;
    logic [63:0] cand = '0;
    logic        sad_valid, best_valid;
    logic [13:0] sad, best_sad;
    logic [3:0]  sad_index, best_index;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;

    int q_sad[$], q_idx[$], q_cyc[$];
    int qb_sad[$], qb_idx[$], qb_cyc[$];

    fme_sad_accumulator dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_start     (in_start),
        .in_last_cand (in_last_cand),
        .orig         (orig),
        .cand         (cand),
        .sad_valid    (sad_valid),
        .sad          (sad),
        .sad_index    (sad_index),
        .best_valid   (best_valid),
        .best_sad     (best_sad),
        .best_index   (best_index)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Record every output pulse with the edge count it followed.
    always @(negedge clock) begin
        if (sad_valid) begin
            q_sad.push_back(int'(sad));
            q_idx.push_back(int'(sad_index));
            q_cyc.push_back(cyc);
        end
        if (best_valid) begin
            qb_sad.push_back(int'(best_sad));
            qb_idx.push_back(int'(best_index));
            qb_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fill(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic clear_q();
        q_sad.delete(); q_idx.delete(); q_cyc.delete();
        qb_sad.delete(); qb_idx.delete(); qb_cyc.delete();
    endtask

    task automatic beat(input logic [63:0] o, input logic [63:0] c, input logic s, input logic l);
        orig = o; cand = c; in_valid = 1'b1; in_start = s; in_last_cand = l;
        @(posedge clock); #1;
        last_cyc = cyc;
        in_valid = 1'b0; in_start = 1'b0; in_last_cand = 1'b0;
    endtask

    task automatic block(input logic [63:0] o0, input logic [63:0] c0,
                         input logic [63:0] o, input logic [63:0] c,
                         input logic st, input logic lc, input int gap);
        for (int r = 0; r < 8; r++) begin
            beat(r == 0 ? o0 : o, r == 0 ? c0 : c, st && r == 0, lc && r == 7);
            if (r != 7) repeat (gap) begin @(posedge clock); #1; end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic chk_one_sad(input string tag, input int exp_sad, input int exp_idx);
        check({tag, "_count"}, q_sad.size(), 1);
        if (q_sad.size() >= 1) begin
            check({tag, "_sad"}, q_sad[0], exp_sad);
            check({tag, "_idx"}, q_idx[0], exp_idx);
            check({tag, "_lat"}, q_cyc[0] - last_cyc, LAT);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_sad_valid"},  int'(sad_valid), 0);
        check({tag, "_best_valid"}, int'(best_valid), 0);
        check({tag, "_sad"},        int'(sad), 0);
        check({tag, "_sad_index"},  int'(sad_index), 0);
        check({tag, "_best_sad"},   int'(best_sad), 16383);
        check({tag, "_best_index"}, int'(best_index), 0);
    endtask

    int c0;

    initial begin
        // Reset state
        idle(3);
        @(negedge clock);
        chk_reset("rst");
        @(posedge clock); #1;
        reset = 1'b0;
        idle(2);

        // Basic block: 8 rows of 8 lanes x |10-7| = 192
        clear_q();
        block(fill(8'd10), fill(8'd7), fill(8'd10), fill(8'd7), 1'b1, 1'b0, 0);
        idle(6);
        chk_one_sad("basic", 192, 0);
        check("basic_hold", int'(sad), 192);
        check("basic_no_best", qb_sad.size(), 0);

        // Back-to-back blocks with no start: candidate index advances, 8-cycle spacing
        clear_q();
        block(fill(8'd10), fill(8'd7), fill(8'd10), fill(8'd7), 1'b1, 1'b0, 0);
        c0 = last_cyc;
        block(fill(8'd3), fill(8'd5), fill(8'd3), fill(8'd5), 1'b0, 1'b0, 0);
        idle(6);
        check("b2b_count", q_sad.size(), 2);
        if (q_sad.size() == 2) begin
            check("b2b_sad0", q_sad[0], 192);
            check("b2b_sad1", q_sad[1], 128);
            check("b2b_idx1", q_idx[1], 1);
            check("b2b_lat0", q_cyc[0] - c0, LAT);
            check("b2b_gap", q_cyc[1] - q_cyc[0], 8);
        end

        // Worst case: 255 vs 0 everywhere
        clear_q();
        block(fill(8'hFF), fill(8'h00), fill(8'hFF), fill(8'h00), 1'b1, 1'b0, 0);
        idle(6);
        chk_one_sad("worst", 16320, 0);

        // Four-candidate search: SADs 100, 50, 50, 80 carried entirely in lane 0 of row 0
        clear_q();
        block(64'd100, '0, '0, '0, 1'b1, 1'b0, 0);
        block(64'd50,  '0, '0, '0, 1'b0, 1'b0, 0);
        block(64'd50,  '0, '0, '0, 1'b0, 1'b0, 0);
        block(64'd80,  '0, '0, '0, 1'b0, 1'b1, 0);
        idle(8);
        check("srch_count", q_sad.size(), 4);
        if (q_sad.size() == 4) begin
            check("srch_sad0", q_sad[0], 100);
            check("srch_sad2", q_sad[2], 50);
            check("srch_idx3", q_idx[3], 3);
            check("srch_sad3", q_sad[3], 80);
        end
        check("best_count", qb_sad.size(), 1);
        if (qb_sad.size() == 1 && q_cyc.size() == 4) begin
            check("best_sad", qb_sad[0], 50);
            check("best_idx", qb_idx[0], 1);
            check("best_lat", qb_cyc[0] - q_cyc[3], 1);
        end
        check("best_hold", int'(best_sad), 50);

        // Bubbles: 3-cycle gaps between rows
        clear_q();
        block(fill(8'd10), fill(8'd7), fill(8'd10), fill(8'd7), 1'b1, 1'b0, 3);
        idle(6);
        chk_one_sad("bubble", 192, 0);

        // Abort: 5 partial rows, then a restarted full block of 1 vs 0
        clear_q();
        for (int r = 0; r < 5; r++) beat(fill(8'd9), fill(8'd0), r == 0, 1'b0);
        block(fill(8'd1), fill(8'd0), fill(8'd1), fill(8'd0), 1'b1, 1'b0, 0);
        idle(6);
        chk_one_sad("abort", 64, 0);

        // Reset after row 3, then a full block without start
        for (int r = 0; r < 4; r++) beat(fill(8'd10), fill(8'd7), r == 0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk_reset("midrst");
        @(posedge clock); #1;
        reset = 1'b0;
        idle(2);
        clear_q();
        block(fill(8'd10), fill(8'd7), fill(8'd10), fill(8'd7), 1'b0, 1'b0, 0);
        idle(6);
        chk_one_sad("postrst", 192, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
